// File: rtl/bcd_pkg.sv
// Shared BCD constants, digit type and validity helper for the N-digit up/down counter.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: parallel load with non-BCD scrubbing, up/down step with wrap,
// and a per-digit terminal flag (9 counting up, 0 counting down).
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       mode,
  input  logic       load,
  input  bcd_digit_t d,
  output bcd_digit_t q,
  output logic       tc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= is_bcd(d) ? d : BCD_MIN;
    end else if (en) begin
      if (mode) begin
        q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end else begin
        q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end
    end
  end

  assign tc = mode ? (q == BCD_MIN) : (q == BCD_MAX);

endmodule

// File: rtl/bcd_ndigit_updown_counter.sv
// Cascadable NDIGIT-digit BCD up/down counter with synchronous load and load_err flag.
// Define BCD_SATURATE_EN to hold at 9..9 / 0..0 instead of wrapping.
module bcd_ndigit_updown_counter
  import bcd_pkg::*;
#(
  parameter int NDIGIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  count,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4*NDIGIT-1:0]   din,
  output logic [4*NDIGIT-1:0]   Q,
  output logic                  TC,
  output logic                  load_err
);

  logic [NDIGIT-1:0] digit_tc;
  logic [NDIGIT:0]   chain;
  logic [NDIGIT-1:0] digit_en;
  logic              any_bad;

  // chain[k] is count qualified by every lower digit sitting at its terminal value
  always_comb begin
    chain[0] = count;
    for (int k = 0; k < NDIGIT; k++) begin
      chain[k+1] = chain[k] & digit_tc[k];
    end
  end

`ifdef BCD_SATURATE_EN
  logic at_limit;
  assign at_limit = &digit_tc;
  always_comb begin
    for (int k = 0; k < NDIGIT; k++) begin
      digit_en[k] = chain[k] & ~at_limit;
    end
  end
`else
  assign digit_en = chain[NDIGIT-1:0];
`endif

  genvar g;
  generate
    for (g = 0; g < NDIGIT; g++) begin : g_digit
      bcd_digit_cell u_cell (
        .clk  (clk),
        .rstn (rstn),
        .en   (digit_en[g]),
        .mode (mode),
        .load (load),
        .d    (din[4*g +: 4]),
        .q    (Q[4*g +: 4]),
        .tc   (digit_tc[g])
      );
    end
  endgenerate

  assign TC = chain[NDIGIT];

  always_comb begin
    any_bad = 1'b0;
    for (int k = 0; k < NDIGIT; k++) begin
      if (!is_bcd(din[4*k +: 4])) any_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load & any_bad;
    end
  end

endmodule

// File: tb/tb_bcd_ndigit_updown_counter.sv
// Self-checking bench: 2-digit counter against a decimal-integer model, plus a
// 1-digit + 1-digit cascade compared with a 2-digit instance.
module tb_bcd_ndigit_updown_counter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       count, mode, load;
  logic [7:0] din;
  logic [7:0] q;
  logic       tc, load_err;

  logic       c_count, c_mode;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc;
  logic [7:0] ref_q;
  logic       ref_tc, lo_err, hi_err, ref_err;

  int vectors = 0;
  int miscompares = 0;

  // model state: plain decimal integers
  int  mv;
  bit  merr;
  int  cv;

  always #5 clk = ~clk;

  bcd_ndigit_updown_counter #(.NDIGIT(2)) dut (
    .clk(clk), .rstn(rstn), .count(count), .mode(mode), .load(load),
    .din(din), .Q(q), .TC(tc), .load_err(load_err));

  bcd_ndigit_updown_counter #(.NDIGIT(1)) u_lo (
    .clk(clk), .rstn(rstn), .count(c_count), .mode(c_mode), .load(1'b0),
    .din(4'h0), .Q(lo_q), .TC(lo_tc), .load_err(lo_err));

  bcd_ndigit_updown_counter #(.NDIGIT(1)) u_hi (
    .clk(clk), .rstn(rstn), .count(lo_tc), .mode(c_mode), .load(1'b0),
    .din(4'h0), .Q(hi_q), .TC(hi_tc), .load_err(hi_err));

  bcd_ndigit_updown_counter #(.NDIGIT(2)) u_ref (
    .clk(clk), .rstn(rstn), .count(c_count), .mode(c_mode), .load(1'b0),
    .din(8'h00), .Q(ref_q), .TC(ref_tc), .load_err(ref_err));

  function automatic int next_val(input int v, input bit m);
`ifdef BCD_SATURATE_EN
    if (!m) return (v == 99) ? 99 : v + 1;
    else    return (v == 0)  ? 0  : v - 1;
`else
    if (!m) return (v + 1) % 100;
    else    return (v == 0) ? 99 : v - 1;
`endif
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic exp_tc(input int v, input logic c, input logic m);
    return c && (m ? (v == 0) : (v == 99));
  endfunction

  // one rising edge; the model consumes the inputs as they stood at that edge
  task automatic apply_edge();
    int lo, hi;
    @(posedge clk);
    if (!rstn) begin
      mv = 0; merr = 0; cv = 0;
    end else begin
      if (load) begin
        lo = int'(din[3:0]); hi = int'(din[7:4]);
        if (lo > 9) lo = 0;
        if (hi > 9) hi = 0;
        mv = hi * 10 + lo;
        merr = (din[3:0] > 4'd9) || (din[7:4] > 4'd9);
      end else begin
        merr = 0;
        if (count) mv = next_val(mv, mode);
      end
      if (c_count) cv = next_val(cv, c_mode);
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; count = 1'b1; mode = 1'b1; load = 1'b1; din = 8'h77;
    c_count = 1'b0; c_mode = 1'b0;
    mv = 0; merr = 0; cv = 0;
    #2;
    vectors++;
    if (q !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_q: got %h want 00", q); end
    vectors++;
    if (load_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b want 0", load_err); end
    vectors++;
    if (tc !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tc: got %b want 1", tc); end
    apply_edge();
    vectors++;
    if (q !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_over_load: got %h want 00", q); end
    @(negedge clk);
    rstn = 1'b1; load = 1'b0; count = 1'b0; mode = 1'b0;
  endtask

  task automatic test_count_up();
    count = 1'b1; mode = 1'b0; load = 1'b0;
    for (int i = 0; i < 100; i++) begin
      apply_edge();
      vectors++;
      if (q !== to_bcd(mv)) begin miscompares++; $display("[TB] FAIL up_q[%0d]: got %h want %h", i, q, to_bcd(mv)); end
      vectors++;
      if (tc !== exp_tc(mv, count, mode)) begin miscompares++; $display("[TB] FAIL up_tc[%0d]: got %b want %b", i, tc, exp_tc(mv, count, mode)); end
    end
  endtask

  task automatic test_count_down();
    load = 1'b1; din = 8'h05; count = 1'b0;
    apply_edge();
    vectors++;
    if (q !== 8'h05) begin miscompares++; $display("[TB] FAIL down_load: got %h want 05", q); end
    load = 1'b0; count = 1'b1; mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_edge();
      vectors++;
      if (q !== to_bcd(mv)) begin miscompares++; $display("[TB] FAIL down_q[%0d]: got %h want %h", i, q, to_bcd(mv)); end
      vectors++;
      if (tc !== exp_tc(mv, count, mode)) begin miscompares++; $display("[TB] FAIL down_tc[%0d]: got %b want %b", i, tc, exp_tc(mv, count, mode)); end
    end
  endtask

  task automatic test_load_err();
    load = 1'b1; count = 1'b0; mode = 1'b0; din = 8'h3C;
    apply_edge();
    vectors++;
    if (q !== 8'h30) begin miscompares++; $display("[TB] FAIL bad_load_q: got %h want 30", q); end
    vectors++;
    if (load_err !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_load_err: got %b want 1", load_err); end
    load = 1'b0;
    apply_edge();
    vectors++;
    if (load_err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_one_cycle: got %b want 0", load_err); end
    vectors++;
    if (q !== 8'h30) begin miscompares++; $display("[TB] FAIL hold_q: got %h want 30", q); end
    load = 1'b1; count = 1'b1; din = 8'h42;
    apply_edge();
    vectors++;
    if (q !== 8'h42) begin miscompares++; $display("[TB] FAIL load_priority: got %h want 42", q); end
    vectors++;
    if (load_err !== 1'b0) begin miscompares++; $display("[TB] FAIL good_load_err: got %b want 0", load_err); end
    load = 1'b0; count = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; din = 8'h56; count = 1'b0; mode = 1'b0;
    apply_edge();
    load = 1'b0; count = 1'b1;
    apply_edge();
    vectors++;
    if (q !== 8'h57) begin miscompares++; $display("[TB] FAIL pre_reset_q: got %h want 57", q); end
    @(negedge clk);
    #2 rstn = 1'b0;
    mv = 0; merr = 0; cv = 0;
    #1;
    vectors++;
    if (q !== 8'h00) begin miscompares++; $display("[TB] FAIL async_clear: got %h want 00", q); end
    mode = 1'b1; count = 1'b1;
    #1;
    vectors++;
    if (tc !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tc_down: got %b want 1", tc); end
    @(negedge clk);
    rstn = 1'b1;
    apply_edge();
    vectors++;
    if (q !== to_bcd(mv)) begin miscompares++; $display("[TB] FAIL resume: got %h want %h", q, to_bcd(mv)); end
    count = 1'b0;
  endtask

  task automatic test_saturate();
    load = 1'b1; din = 8'h98; mode = 1'b0; count = 1'b0;
    apply_edge();
    load = 1'b0; count = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_edge();
      vectors++;
      if (q !== to_bcd(mv)) begin miscompares++; $display("[TB] FAIL sat_up[%0d]: got %h want %h", i, q, to_bcd(mv)); end
    end
    load = 1'b1; din = 8'h01; count = 1'b0;
    apply_edge();
    load = 1'b0; count = 1'b1; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_edge();
      vectors++;
      if (q !== to_bcd(mv)) begin miscompares++; $display("[TB] FAIL sat_dn[%0d]: got %h want %h", i, q, to_bcd(mv)); end
      vectors++;
      if (tc !== exp_tc(mv, count, mode)) begin miscompares++; $display("[TB] FAIL sat_tc[%0d]: got %b want %b", i, tc, exp_tc(mv, count, mode)); end
    end
    count = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      din   = 8'($urandom);
      count = ($urandom_range(0, 3) != 0);
      mode  = $urandom_range(0, 1) == 1;
      apply_edge();
      vectors++;
      if (q !== to_bcd(mv)) begin miscompares++; $display("[TB] FAIL rnd_q[%0d]: got %h want %h", i, q, to_bcd(mv)); end
      vectors++;
      if (load_err !== merr) begin miscompares++; $display("[TB] FAIL rnd_err[%0d]: got %b want %b", i, load_err, merr); end
      vectors++;
      if (tc !== exp_tc(mv, count, mode)) begin miscompares++; $display("[TB] FAIL rnd_tc[%0d]: got %b want %b", i, tc, exp_tc(mv, count, mode)); end
      // TC must follow a mid-cycle mode change without waiting for an edge
      mode = ~mode;
      #1;
      vectors++;
      if (tc !== exp_tc(mv, count, mode)) begin miscompares++; $display("[TB] FAIL mode_tc[%0d]: got %b want %b", i, tc, exp_tc(mv, count, mode)); end
    end
    load = 1'b0; count = 1'b0;
  endtask

  task automatic test_cascade();
    c_mode = 1'b0;
    for (int i = 0; i < 120; i++) begin
      c_count = ($urandom_range(0, 7) != 0);
      apply_edge();
      vectors++;
      if ({hi_q, lo_q} !== ref_q) begin miscompares++; $display("[TB] FAIL cas_vs_ref[%0d]: got %h want %h", i, {hi_q, lo_q}, ref_q); end
      vectors++;
      if ({hi_q, lo_q} !== to_bcd(cv)) begin miscompares++; $display("[TB] FAIL cas_model[%0d]: got %h want %h", i, {hi_q, lo_q}, to_bcd(cv)); end
      vectors++;
      if (hi_tc !== exp_tc(cv, c_count, c_mode)) begin miscompares++; $display("[TB] FAIL cas_tc[%0d]: got %b want %b", i, hi_tc, exp_tc(cv, c_count, c_mode)); end
    end
    c_count = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_err();
    test_async_reset();
    test_saturate();
    test_random();
    test_cascade();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
